calc_operand_entry: RTL and testbench

//  Sequential input front-end for the 4-bit calculator. Debounces the board pushbuttons
//  and walks the user through entering A, then B, then OP from the switches. Presents the

---
 rtl/calc_pkg.sv | 39 +++
 rtl/calc_operand_entry_if.sv | 27 ++
 rtl/calc_operand_entry_key_debounce.sv | 44 ++++
 rtl/calc_operand_entry.sv | 98 +++++++++
 tb/tb_calc_operand_entry.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit calculator front-end:
// widths, entry states, debounce default and prompt glyphs.
package calc_pkg;

    localparam int W                  = 4;
    localparam int OPW                = 3;
    localparam int DB_CYCLES_DEFAULT  = 500000;

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_OP   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_A    = S_A,
        ST_B    = S_B,
        ST_OP   = S_OP,
        ST_DONE = S_DONE
    } state_t;

    // Active-low segments, bit order gfedcba.
    localparam logic [6:0] GLYPH_A    = 7'b0001000;
    localparam logic [6:0] GLYPH_B    = 7'b0000011;
    localparam logic [6:0] GLYPH_OP   = 7'b0100011;
    localparam logic [6:0] GLYPH_DONE = 7'b0100001;

    function automatic logic [6:0] prompt_glyph(input logic [1:0] s);
        logic [6:0] g;
        g = GLYPH_A;
        case (s)
            S_B:     g = GLYPH_B;
            S_OP:    g = GLYPH_OP;
            S_DONE:  g = GLYPH_DONE;
            default: g = GLYPH_A;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/calc_operand_entry_if.sv
// Board-side bus of the operand entry block: raw keys and
// switches in, captured operands and entry progress out.
interface calc_operand_entry_if #(
    parameter int W   = calc_pkg::W,
    parameter int OPW = calc_pkg::OPW
);

    logic [1:0]     KEY_n;
    logic [W-1:0]   SW;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [OPW-1:0] OP;
    logic           operands_valid;
    logic           start;
    logic [1:0]     stage;

    modport master (
        output KEY_n, SW,
        input  A, B, OP, operands_valid, start, stage
    );

    modport slave (
        input  KEY_n, SW,
        output A, B, OP, operands_valid, start, stage
    );

endinterface

// File: rtl/calc_operand_entry_key_debounce.sv
// One pushbutton: 2-FF synchronizer, hold-time debouncer and a
// single-cycle press pulse on the released->pressed transition.
module key_debounce #(
    parameter int DB_CYCLES = calc_pkg::DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          stable_n;
    logic [CW-1:0] cnt;

    // Synchronize, then accept a new level only after it has held long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable_n <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable_n) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable_n <= sync2;
                cnt      <= '0;
                press    <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_operand_entry.sv
// Walks the user through entering A, B and OP from the switches,
// driven by debounced ENTER/CLEAR presses.
module calc_operand_entry
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    calc_operand_entry_if.slave  bus
);

    logic           enter_p;
    logic           clear_p;
    state_t         state;
    logic [W-1:0]   a_val;
    logic [W-1:0]   b_val;
    logic [OPW-1:0] op_val;
    logic           valid;
    logic           start_pulse;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_enter (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (bus.KEY_n[0]),
        .press (enter_p)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (bus.KEY_n[1]),
        .press (clear_p)
    );

    // Entry FSM; CLEAR takes priority and a coincident ENTER is dropped.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= ST_A;
            a_val       <= '0;
            b_val       <= '0;
            op_val      <= '0;
            valid       <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            if (clear_p) begin
                unique case (state)
                    ST_A: a_val <= '0;
                    ST_B: begin
                        b_val <= '0;
                        state <= ST_A;
                    end
                    ST_OP: begin
                        op_val <= '0;
                        state  <= ST_B;
                    end
                    ST_DONE: begin
                        a_val  <= '0;
                        b_val  <= '0;
                        op_val <= '0;
                        valid  <= 1'b0;
                        state  <= ST_A;
                    end
                endcase
            end else if (enter_p) begin
                unique case (state)
                    ST_A: begin
                        a_val <= bus.SW;
                        state <= ST_B;
                    end
                    ST_B: begin
                        b_val <= bus.SW;
                        state <= ST_OP;
                    end
                    ST_OP: begin
                        op_val      <= bus.SW[OPW-1:0];
                        valid       <= 1'b1;
                        start_pulse <= 1'b1;
                        state       <= ST_DONE;
                    end
                    ST_DONE: begin
                        valid <= 1'b0;
                        state <= ST_A;
                    end
                endcase
            end
        end
    end

    assign bus.A              = a_val;
    assign bus.B              = b_val;
    assign bus.OP             = op_val;
    assign bus.operands_valid = valid;
    assign bus.start          = start_pulse;
    assign bus.stage          = state;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed bench for calc_operand_entry with a cycle-level
// behavioural model compared on every falling edge.
module tb_calc_operand_entry;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    calc_operand_entry_if bus ();

    calc_operand_entry #(.DB_CYCLES(DB)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model state.
    int         m_a, m_b, m_op, m_stage;
    bit         m_valid, m_start;
    logic [1:0] h1, h2, mst;
    int         run [2];
    bit [1:0]   pend;
    bit [1:0]   act;
    bit         armed = 1'b0;

    // A key level seen (two cycles late) differing from the accepted
    // level for DB+1 consecutive cycles becomes the accepted level;
    // a new press is acted on one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
            m_valid = 0; m_start = 0;
            h1 = 2'b11; h2 = 2'b11; mst = 2'b11;
            run[0] = 0; run[1] = 0;
            pend = 2'b00;
            armed = 1'b1;
        end else begin
            act = pend;
            pend = 2'b00;
            m_start = 0;
            if (act[1]) begin
                case (m_stage)
                    0: m_a = 0;
                    1: begin m_b = 0; m_stage = 0; end
                    2: begin m_op = 0; m_stage = 1; end
                    default: begin
                        m_a = 0; m_b = 0; m_op = 0;
                        m_valid = 0; m_stage = 0;
                    end
                endcase
            end else if (act[0]) begin
                case (m_stage)
                    0: begin m_a = int'(bus.SW); m_stage = 1; end
                    1: begin m_b = int'(bus.SW); m_stage = 2; end
                    2: begin
                        m_op = int'(bus.SW) % 8;
                        m_stage = 3; m_start = 1; m_valid = 1;
                    end
                    default: begin m_stage = 0; m_valid = 0; end
                endcase
            end
            for (int k = 0; k < 2; k++) begin
                if (h2[k] != mst[k]) begin
                    run[k]++;
                    if (run[k] == DB + 1) begin
                        mst[k] = h2[k];
                        run[k] = 0;
                        if (!h2[k]) pend[k] = 1'b1;
                    end
                end else begin
                    run[k] = 0;
                end
            end
            h2 = h1;
            h1 = bus.KEY_n;
        end
    end

    // Compare every output against the model each cycle.
    always @(negedge clk) begin
        if (armed) begin
            chk("A", 32'(bus.A), 32'(m_a));
            chk("B", 32'(bus.B), 32'(m_b));
            chk("OP", 32'(bus.OP), 32'(m_op));
            chk("stage", 32'(bus.stage), 32'(m_stage));
            chk("valid", 32'(bus.operands_valid), 32'(m_valid));
            chk("start", 32'(bus.start), 32'(m_start));
            if (bus.start === 1'b1) start_cnt++;
        end
    end

    task automatic press(input logic [1:0] mask, input logic [3:0] sw);
        bus.SW = sw;
        bus.KEY_n = ~mask;
        repeat (8) @(negedge clk);
        bus.KEY_n = 2'b11;
        repeat (12) @(negedge clk);
    endtask

    int sc;

    initial begin
        bus.KEY_n = 2'b11;
        bus.SW = 4'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_A", 32'(bus.A), 0);
        chk("rst_stage", 32'(bus.stage), 0);
        chk("rst_valid", 32'(bus.operands_valid), 0);
        chk("rst_start", 32'(bus.start), 0);
        rst = 1'b0;

        press(2'b01, 4'b0011);
        chk("enterA_A", 32'(bus.A), 3);
        chk("enterA_stage", 32'(bus.stage), 1);
        press(2'b01, 4'b1110);
        chk("enterB_B", 32'(bus.B), 14);
        chk("enterB_stage", 32'(bus.stage), 2);

        rst = 1'b1;
        @(negedge clk);
        chk("midrst_A", 32'(bus.A), 0);
        chk("midrst_B", 32'(bus.B), 0);
        chk("midrst_OP", 32'(bus.OP), 0);
        chk("midrst_stage", 32'(bus.stage), 0);
        chk("midrst_valid", 32'(bus.operands_valid), 0);
        chk("midrst_start", 32'(bus.start), 0);
        rst = 1'b0;

        press(2'b01, 4'b0011);
        press(2'b01, 4'b1110);
        sc = start_cnt;
        press(2'b01, 4'b1010);
        chk("op_OP", 32'(bus.OP), 2);
        chk("op_stage", 32'(bus.stage), 3);
        chk("op_valid", 32'(bus.operands_valid), 1);
        chk("op_start_count", 32'(start_cnt - sc), 1);

        bus.KEY_n = 2'b10;
        repeat (3) @(negedge clk);
        bus.KEY_n = 2'b11;
        repeat (12) @(negedge clk);
        chk("glitch_stage", 32'(bus.stage), 3);

        bus.KEY_n = 2'b10;
        repeat (7) @(negedge clk);
        chk("hold_before_stage", 32'(bus.stage), 3);
        @(negedge clk);
        chk("hold_edge_stage", 32'(bus.stage), 0);
        chk("hold_edge_valid", 32'(bus.operands_valid), 0);
        repeat (42) @(negedge clk);
        bus.KEY_n = 2'b11;
        repeat (15) @(negedge clk);
        chk("hold_once_stage", 32'(bus.stage), 0);
        chk("hold_A", 32'(bus.A), 3);
        chk("hold_B", 32'(bus.B), 14);
        chk("hold_OP", 32'(bus.OP), 2);

        press(2'b01, 4'd5);
        press(2'b01, 4'd7);
        press(2'b10, 4'd0);
        chk("clrOP_OP", 32'(bus.OP), 0);
        chk("clrOP_stage", 32'(bus.stage), 1);
        press(2'b10, 4'd0);
        chk("clrB_B", 32'(bus.B), 0);
        chk("clrB_stage", 32'(bus.stage), 0);
        chk("clrB_A", 32'(bus.A), 5);

        press(2'b01, 4'd5);
        press(2'b01, 4'd9);
        chk("preboth_stage", 32'(bus.stage), 2);
        press(2'b10, 4'd0);
        press(2'b11, 4'd9);
        chk("both_B", 32'(bus.B), 0);
        chk("both_stage", 32'(bus.stage), 0);

        press(2'b01, 4'd6);
        press(2'b01, 4'd1);
        press(2'b01, 4'b0111);
        chk("done_OP", 32'(bus.OP), 7);
        chk("done_stage", 32'(bus.stage), 3);
        press(2'b10, 4'd0);
        chk("doneclr_A", 32'(bus.A), 0);
        chk("doneclr_B", 32'(bus.B), 0);
        chk("doneclr_OP", 32'(bus.OP), 0);
        chk("doneclr_stage", 32'(bus.stage), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
